// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : intersection_scheduler
// Purpose  : Round-robin GREEN/YELLOW/ALL_RED phase sequencer for N roads; road 0 is home.
//            Optional macro PED_WALK_EN adds a pedestrian WALK phase.
// Revision : 1.0
// ============================================================================
module intersection_scheduler #(
    parameter int N_RD      = 4,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int Y2RDELAY  = 3,
    parameter int R2GDELAY  = 2,
    parameter int CNT_W     = 5,
    parameter int PED_TIME  = 6
) (
    input  logic                CLOCK,
    input  logic                CLEAR,
    input  logic [N_RD-1:0]     CAR_REQ,
`ifdef PED_WALK_EN
    input  logic                PED_REQ,
    output logic                WALK,
`endif
    output logic [2*N_RD-1:0]   SIG,
    output logic [N_RD-1:0]     GRANT,
    output logic                PHASE_DONE
);
    localparam int CUR_W = (N_RD > 1) ? $clog2(N_RD) : 1;
    localparam int c_M1  = (MAX_GREEN > Y2RDELAY) ? MAX_GREEN : Y2RDELAY;
    localparam int c_M2  = (c_M1 > R2GDELAY) ? c_M1 : R2GDELAY;
    localparam int c_M3  = (c_M2 > PED_TIME) ? c_M2 : PED_TIME;

    localparam logic [CNT_W-1:0] c_MIN_G = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] c_MAX_G = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] c_YEL_T = CNT_W'(Y2RDELAY - 1);
    localparam logic [CNT_W-1:0] c_RED_T = CNT_W'(R2GDELAY - 1);
    localparam logic [CNT_W-1:0] c_TSAT  = CNT_W'(c_M3 - 1);
    localparam logic [1:0]       c_L_YEL = 2'd1;
    localparam logic [1:0]       c_L_GRN = 2'd2;

`ifdef PED_WALK_EN
    localparam logic [CNT_W-1:0] c_WALK_T = CNT_W'(PED_TIME - 1);
    typedef enum logic [2:0] {S_GREEN, S_YELLOW, S_ALLRED, S_WALK, S_CLEAR2} state_t;
`else
    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED} state_t;
`endif

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_timer, w_timer_nxt, w_tlim;
    logic [CUR_W-1:0]   r_cur, r_nxt, w_cur_nxt, w_nxt_nxt, w_tgt, w_ri;
    logic               w_found, w_tgt_ok, w_want, w_go;
    int                 w_idx;
    logic [2*N_RD-1:0]  r_sig, w_sig;
    logic [N_RD-1:0]    r_grant, w_grant;
    logic               r_pd, w_pd;
`ifdef PED_WALK_EN
    logic               r_ped_pend, r_walk, w_walk;
`endif

    // First requesting road after cur in cyclic order; defaults to home road.
    always_comb begin
        w_found = 1'b0;
        w_tgt   = '0;
        w_idx   = 0;
        w_ri    = '0;
        for (int k = 1; k < N_RD; k++) begin
            w_idx = int'(r_cur) + k;
            if (w_idx >= N_RD) w_idx = w_idx - N_RD;
            w_ri = CUR_W'(w_idx);
            if (!w_found && CAR_REQ[w_ri]) begin
                w_found = 1'b1;
                w_tgt   = w_ri;
            end
        end
        w_tgt_ok = w_found || ((r_cur != '0) && !CAR_REQ[r_cur]);
`ifdef PED_WALK_EN
        w_want   = w_tgt_ok || r_ped_pend;
`else
        w_want   = w_tgt_ok;
`endif
        w_go = (r_timer >= c_MIN_G) && w_want && (!CAR_REQ[r_cur] || (r_timer >= c_MAX_G));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_nxt_nxt   = r_nxt;
        case (r_state)
            S_GREEN: begin
                if (w_go) begin
                    w_state_nxt = S_YELLOW;
                    w_nxt_nxt   = w_tgt;
                end
            end
            S_YELLOW: begin
                if (r_timer == c_YEL_T) w_state_nxt = S_ALLRED;
            end
            S_ALLRED: begin
                if (r_timer == c_RED_T) begin
`ifdef PED_WALK_EN
                    if (r_ped_pend) begin
                        w_state_nxt = S_WALK;
                    end else begin
                        w_state_nxt = S_GREEN;
                        w_cur_nxt   = r_nxt;
                    end
`else
                    w_state_nxt = S_GREEN;
                    w_cur_nxt   = r_nxt;
`endif
                end
            end
`ifdef PED_WALK_EN
            S_WALK: begin
                if (r_timer == c_WALK_T) w_state_nxt = S_CLEAR2;
            end
            S_CLEAR2: begin
                if (r_timer == c_RED_T) begin
                    w_state_nxt = S_GREEN;
                    w_cur_nxt   = r_nxt;
                end
            end
`endif
            default: begin
                w_state_nxt = S_GREEN;
                w_cur_nxt   = '0;
            end
        endcase

        // GREEN saturates so an uncontested road can hold indefinitely.
        w_tlim = (r_state == S_GREEN) ? c_MAX_G : c_TSAT;
        if (w_state_nxt != r_state)  w_timer_nxt = '0;
        else if (r_timer < w_tlim)   w_timer_nxt = r_timer + 1'b1;
        else                         w_timer_nxt = r_timer;
    end

    always_comb begin
        w_sig   = '0;
        w_grant = '0;
        for (int i = 0; i < N_RD; i++) begin
            if (CUR_W'(i) == w_cur_nxt) begin
                if (w_state_nxt == S_GREEN) begin
                    w_sig[2*i +: 2] = c_L_GRN;
                    w_grant[i]      = 1'b1;
                end else if (w_state_nxt == S_YELLOW) begin
                    w_sig[2*i +: 2] = c_L_YEL;
                    w_grant[i]      = 1'b1;
                end
            end
        end
        w_pd = (w_state_nxt == S_GREEN) && (r_state != S_GREEN);
`ifdef PED_WALK_EN
        w_walk = (w_state_nxt == S_WALK);
`endif
    end

    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            r_state <= S_GREEN;
            r_timer <= '0;
            r_cur   <= '0;
            r_nxt   <= '0;
            r_sig   <= {{(2*N_RD-2){1'b0}}, c_L_GRN};
            r_grant <= N_RD'(1);
            r_pd    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_cur   <= w_cur_nxt;
            r_nxt   <= w_nxt_nxt;
            r_sig   <= w_sig;
            r_grant <= w_grant;
            r_pd    <= w_pd;
        end
    end

`ifdef PED_WALK_EN
    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            r_ped_pend <= 1'b0;
            r_walk     <= 1'b0;
        end else begin
            r_walk <= w_walk;
            if (w_walk && (r_state != S_WALK)) r_ped_pend <= 1'b0;
            else if (PED_REQ)                  r_ped_pend <= 1'b1;
        end
    end
    assign WALK = r_walk;
`endif

    assign SIG        = r_sig;
    assign GRANT      = r_grant;
    assign PHASE_DONE = r_pd;

endmodule
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_intersection_scheduler
// Purpose  : Vector-table and scoreboard bench for intersection_scheduler (N_RD=4).
// Revision : 1.0
// ============================================================================
module tb_intersection_scheduler;
    typedef struct {
        logic [3:0] req;
        logic       ped;
        int         n;
        logic [7:0] sig;
        logic [3:0] grant;
        logic       pd;
        logic       walk;
    } vec_t;

    typedef struct {
        logic [7:0] sig;
        logic [3:0] grant;
        logic       pd;
        logic       walk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] car_req = '0;
    logic       ped_req = 1'b0;
    logic [7:0] sig;
    logic [3:0] grant;
    logic       pd;
    logic       walk_a;
`ifdef PED_WALK_EN
    logic       walk;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    vec_t tbl[0:29];
    vec_t tail[0:1];

    always #5 clk = ~clk;

    intersection_scheduler #(
        .N_RD(4), .MIN_GREEN(4), .MAX_GREEN(12), .Y2RDELAY(3),
        .R2GDELAY(2), .CNT_W(5), .PED_TIME(6)
    ) dut (
        .CLOCK     (clk),
        .CLEAR     (rst),
        .CAR_REQ   (car_req),
`ifdef PED_WALK_EN
        .PED_REQ   (ped_req),
        .WALK      (walk),
`endif
        .SIG       (sig),
        .GRANT     (grant),
        .PHASE_DONE(pd)
    );

`ifdef PED_WALK_EN
    assign walk_a = walk;
`else
    assign walk_a = 1'b0;
`endif

    function automatic vec_t mk(input logic [3:0] req, input logic ped, input int n,
                                input logic [7:0] s, input logic [3:0] g,
                                input logic p, input logic w);
        vec_t v;
        v.req = req; v.ped = ped; v.n = n; v.sig = s; v.grant = g; v.pd = p; v.walk = w;
        return v;
    endfunction

    task automatic check_pop(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (sig !== e.sig || grant !== e.grant || pd !== e.pd || walk_a !== e.walk) begin
            n_fail++;
            $display("FAIL %s @%0t: SIG=%h GRANT=%b PD=%b WALK=%b, expected SIG=%h GRANT=%b PD=%b WALK=%b",
                     name, $time, sig, grant, pd, walk_a, e.sig, e.grant, e.pd, e.walk);
        end
    endtask

    task automatic check_now(input string name, input logic [7:0] s, input logic [3:0] g);
        exp_t e;
        e.sig = s; e.grant = g; e.pd = 1'b0; e.walk = 1'b0;
        sb.push_back(e);
        #1;
        check_pop(name);
    endtask

    // Entered and left just after a falling edge.
    task automatic drive_cycle(input string name, input logic [3:0] req, input logic ped, input exp_t e);
        car_req = req;
        ped_req = ped;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_pop(name);
        @(negedge clk);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        exp_t e;
        for (int i = 0; i < v.n; i++) begin
            e.sig = v.sig; e.grant = v.grant; e.walk = v.walk;
            e.pd  = v.pd && (i == 0);
            drive_cycle(name, v.req, (i == 0) ? v.ped : 1'b0, e);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        car_req = '0;
        ped_req = 1'b0;
        check_now("reset_assert", 8'h02, 4'b0001);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check_now("reset_release", 8'h02, 4'b0001);
    endtask

    initial begin
        exp_t e;
        tbl[0]  = mk(4'b0010, 0,  3, 8'h02, 4'b0001, 0, 0);
        tbl[1]  = mk(4'b0010, 0,  3, 8'h01, 4'b0001, 0, 0);
        tbl[2]  = mk(4'b0010, 0,  2, 8'h00, 4'b0000, 0, 0);
        tbl[3]  = mk(4'b0110, 0,  1, 8'h08, 4'b0010, 1, 0);
        tbl[4]  = mk(4'b0110, 0, 11, 8'h08, 4'b0010, 0, 0);
        tbl[5]  = mk(4'b0110, 0,  3, 8'h04, 4'b0010, 0, 0);
        tbl[6]  = mk(4'b0110, 0,  2, 8'h00, 4'b0000, 0, 0);
        tbl[7]  = mk(4'b0010, 0,  1, 8'h20, 4'b0100, 1, 0);
        tbl[8]  = mk(4'b0010, 0,  3, 8'h20, 4'b0100, 0, 0);
        tbl[9]  = mk(4'b0010, 0,  3, 8'h10, 4'b0100, 0, 0);
        tbl[10] = mk(4'b0010, 0,  2, 8'h00, 4'b0000, 0, 0);
        tbl[11] = mk(4'b1001, 0,  1, 8'h08, 4'b0010, 1, 0);
        tbl[12] = mk(4'b1001, 0,  3, 8'h08, 4'b0010, 0, 0);
        tbl[13] = mk(4'b1001, 0,  3, 8'h04, 4'b0010, 0, 0);
        tbl[14] = mk(4'b1001, 0,  2, 8'h00, 4'b0000, 0, 0);
        tbl[15] = mk(4'b0001, 0,  1, 8'h80, 4'b1000, 1, 0);
        tbl[16] = mk(4'b0001, 0,  3, 8'h80, 4'b1000, 0, 0);
        tbl[17] = mk(4'b0001, 0,  3, 8'h40, 4'b1000, 0, 0);
        tbl[18] = mk(4'b0001, 0,  2, 8'h00, 4'b0000, 0, 0);
        tbl[19] = mk(4'b0100, 0,  1, 8'h02, 4'b0001, 1, 0);
        tbl[20] = mk(4'b0100, 0,  3, 8'h02, 4'b0001, 0, 0);
        tbl[21] = mk(4'b0100, 0,  1, 8'h01, 4'b0001, 0, 0);
        tbl[22] = mk(4'b1000, 0,  2, 8'h01, 4'b0001, 0, 0);
        tbl[23] = mk(4'b0000, 0,  2, 8'h00, 4'b0000, 0, 0);
        tbl[24] = mk(4'b0000, 0,  1, 8'h20, 4'b0100, 1, 0);
        tbl[25] = mk(4'b0000, 0,  3, 8'h20, 4'b0100, 0, 0);
        tbl[26] = mk(4'b0000, 0,  3, 8'h10, 4'b0100, 0, 0);
        tbl[27] = mk(4'b0000, 0,  2, 8'h00, 4'b0000, 0, 0);
        tbl[28] = mk(4'b0000, 0,  1, 8'h02, 4'b0001, 1, 0);
        tbl[29] = mk(4'b0000, 0,  6, 8'h02, 4'b0001, 0, 0);
        tail[0] = mk(4'b0010, 0,  3, 8'h02, 4'b0001, 0, 0);
        tail[1] = mk(4'b0010, 0,  1, 8'h01, 4'b0001, 0, 0);

        // Reset and idle hold on the home road.
        repeat (5) @(negedge clk);
        check_now("reset_hold", 8'h02, 4'b0001);
        rst = 1'b0;
        e.sig = 8'h02; e.grant = 4'b0001; e.pd = 1'b0; e.walk = 1'b0;
        for (int i = 0; i < 40; i++) drive_cycle("idle_hold", 4'b0000, 1'b0, e);

        // Handover, max green, wrap, latched target, return home.
        do_reset();
        for (int i = 0; i < 30; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Reset during the second YELLOW cycle.
        e.sig = 8'h01; e.grant = 4'b0001; e.pd = 1'b0; e.walk = 1'b0;
        drive_cycle("yel1", 4'b0010, 1'b0, e);
        drive_cycle("yel2", 4'b0010, 1'b0, e);
        do_reset();
        for (int i = 0; i < 2; i++) run_vec($sformatf("post_rst%0d", i), tail[i]);

`ifdef PED_WALK_EN
        do_reset();
        run_vec("ped_green", mk(4'b0000, 1, 3, 8'h02, 4'b0001, 0, 0));
        run_vec("ped_yel",   mk(4'b0000, 0, 3, 8'h01, 4'b0001, 0, 0));
        run_vec("ped_red1",  mk(4'b0000, 0, 2, 8'h00, 4'b0000, 0, 0));
        run_vec("ped_walk",  mk(4'b0000, 0, 6, 8'h00, 4'b0000, 0, 1));
        run_vec("ped_red2",  mk(4'b0000, 0, 2, 8'h00, 4'b0000, 0, 0));
        run_vec("ped_home",  mk(4'b0000, 0, 1, 8'h02, 4'b0001, 1, 0));
        run_vec("ped_hold",  mk(4'b0000, 0, 4, 8'h02, 4'b0001, 0, 0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
`default_nettype wire

// File: doc/intersection_scheduler.md
Name: intersection_scheduler

Overview:
- Sequences signal phases for an N-road intersection. Only one road is ever GREEN; roads with waiting cars take turns (round-robin).
- Generalises the two-road main/country controller. Road 0 is the home road: it holds GREEN when nobody else is waiting.
- Drives the per-road 2-bit signal heads and a one-hot grant vector. Sits directly above the lamp drivers.

Parameters:
- N_RD, 4, number of roads (2..8).
- MIN_GREEN, 4, minimum GREEN cycles before a phase may be pre-empted.
- MAX_GREEN, 12, maximum GREEN cycles while any other road is requesting.
- Y2RDELAY, 3, YELLOW duration in cycles.
- R2GDELAY, 2, ALL_RED clearance duration in cycles.
- CNT_W, 5, phase timer width; must hold max(MAX_GREEN, Y2RDELAY, R2GDELAY, PED_TIME).
- PED_TIME, 6, WALK duration in cycles (used only with PED_WALK_EN).

Ports:
- CLOCK  in  1  system clock; all state updates on the rising edge.
- CLEAR  in  1  asynchronous, active-high reset.
- CAR_REQ  in  N_RD  level car-present sensor per road; sampled every cycle.
- SIG  out  2*N_RD  signal head per road at [2i+1:2i]: RED=2'd0, YELLOW=2'd1, GREEN=2'd2; 2'd3 is never driven.
- GRANT  out  N_RD  one-hot; the road currently GREEN or YELLOW; all zero in ALL_RED.
- PHASE_DONE  out  1  one-cycle pulse on the cycle a new GREEN begins.

Behaviour:
- Reset (CLEAR high, asynchronous):
  - state=GREEN, cur=0, timer=0.
  - SIG: road 0 GREEN, all others RED (N_RD=4: 8'h02).
  - GRANT=1, PHASE_DONE=0.
- Phase timer:
  - Cleared on every state change; otherwise +1 per cycle.
  - A state lasting D cycles exits on the edge where timer==D-1.
- State machine: GREEN -> YELLOW -> ALL_RED -> GREEN.
- GREEN exit condition (evaluated every cycle), all three must hold:
  - timer >= MIN_GREEN-1;
  - a target road != cur exists;
  - CAR_REQ[cur]==0, or timer >= MAX_GREEN-1.
- Target selection:
  - First requesting road in cyclic order cur+1, cur+2, … (wrapping), excluding cur.
  - If no other road requests and cur != 0 and CAR_REQ[cur]==0, the target is road 0 (return home).
  - If cur==0 and no other road requests, road 0 holds GREEN indefinitely; the timer saturates at MAX_GREEN-1.
- The target is latched into nxt on the GREEN->YELLOW edge. Later CAR_REQ changes do not alter nxt.
- YELLOW: SIG[cur]=YELLOW for exactly Y2RDELAY cycles, then ALL_RED.
- ALL_RED: all roads RED and GRANT=0 for exactly R2GDELAY cycles.
- Leaving ALL_RED: cur<=nxt, SIG[cur]=GREEN, GRANT set, PHASE_DONE=1 for that first GREEN cycle only.
- Requests dropping during YELLOW or ALL_RED do not abort the sequence; the latched road still gets its MIN_GREEN.
- All outputs are registered (no combinational path from CAR_REQ to SIG).
- CLEAR asserted in any state, mid-count, returns to the reset values immediately.

Optional Feature:
- Macro: PED_WALK_EN.
- When defined, adds two ports:
  - PED_REQ, in, 1, pedestrian button;
  - WALK, out, 1, walk lamp.
- PED_REQ behaviour:
  - A pulse is latched into ped_pend, which clears on WALK entry.
  - If ped_pend is set, the GREEN exit condition treats it as an other-road request.
  - After ALL_RED, a WALK state runs instead of the next GREEN: all SIG RED, WALK=1, GRANT=0, for PED_TIME cycles.
  - WALK is followed by a further ALL_RED of R2GDELAY cycles, then GREEN for nxt.
  - If no car target exists, nxt=0.
- When not defined: no PED ports, no WALK state; behaviour exactly as above.

Test Plan:
- Reset and hold: CLEAR high 5 negedges, CAR_REQ=0 for 40 cycles -> SIG=8'h02 and GRANT=4'b0001 throughout; PHASE_DONE never pulses.
- Basic handover: CAR_REQ=4'b0010 held from reset release ->
  - road 0 GREEN 4 cycles;
  - SIG=8'h01 for 3 cycles;
  - 8'h00 for 2 cycles;
  - then 8'h08 with PHASE_DONE for one cycle.
- Max green: after road 1 is GREEN, CAR_REQ=4'b0110 held -> road 1 GREEN exactly 12 cycles, then YELLOW 3 cycles, ALL_RED 2 cycles, then road 2 GREEN (SIG=8'h20).
- Round-robin wrap: cur=1, CAR_REQ=4'b1001 -> next GREEN is road 3 (SIG=8'h80). Then, with CAR_REQ=4'b0001, road 0 follows after the minimum green.
- Return home: road 2 GREEN and CAR_REQ drops to 0 -> exits at timer=3; road 0 GREEN 5 cycles later.
- Reset mid-YELLOW: assert CLEAR on the 2nd YELLOW cycle -> SIG=8'h02 and GRANT=1 before the next CLOCK edge. With PED_WALK_EN: PED_REQ pulse during road 0 GREEN with CAR_REQ=0 -> YELLOW, ALL_RED, 6 cycles WALK=1 with SIG=8'h00, ALL_RED 2 cycles, then road 0 GREEN.
